// File: rtl/uart_pkg.sv
// Shared types and constants for the UART controller-frame decoder.
package uart_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned GAP_W   = 16;
    localparam int unsigned ERR_W   = 2;

    localparam logic [BYTE_W-1:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [STATE_W-1:0] {
        s_IDLE  = 3'd0,
        s_CMD   = 3'd1,
        s_DATA0 = 3'd2,
        s_DATA1 = 3'd3,
        s_CHECK = 3'd4
    } state_t;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 2'b00,
        ERR_CHECKSUM = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_t;

    // Payload of a decoded frame as presented to the game logic.
    typedef struct packed {
        logic [BYTE_W-1:0]   cmd;
        logic [2*BYTE_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input and decoded-frame output bundle of the frame decoder.
interface uart_frame_decoder_if;
    import uart_pkg::*;

    logic                     i_RX_DATA_VALID;
    logic [BYTE_W-1:0]        i_DATA_RX;
    logic                     o_FRAME_VALID;
    logic [BYTE_W-1:0]        o_CMD;
    logic [2*BYTE_W-1:0]      o_DATA;
    logic                     o_FRAME_ERROR;
    logic [ERR_W-1:0]         o_ERR_CODE;

    modport master (
        output i_RX_DATA_VALID, i_DATA_RX,
        input  o_FRAME_VALID, o_CMD, o_DATA, o_FRAME_ERROR, o_ERR_CODE
    );

    modport slave (
        input  i_RX_DATA_VALID, i_DATA_RX,
        output o_FRAME_VALID, o_CMD, o_DATA, o_FRAME_ERROR, o_ERR_CODE
    );

endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles 5-byte controller frames (header, cmd, data0, data1, XOR checksum)
// from the UART receiver byte stream; flags checksum errors and inter-byte timeouts.
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter int unsigned        c_TIMEOUT_CYCLES = 21700,
    parameter logic [BYTE_W-1:0]  c_HEADER         = DEFAULT_HEADER
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET_n,
    uart_frame_decoder_if.slave   bus
);

    localparam logic [GAP_W-1:0] TIMEOUT_LAST = GAP_W'(c_TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [GAP_W-1:0]    gap_cnt;
    logic [BYTE_W-1:0]   run_xor;
    logic [BYTE_W-1:0]   cmd_q;
    logic [BYTE_W-1:0]   data0_q;
    logic [BYTE_W-1:0]   data1_q;
    frame_t              frame;
    logic                frame_valid;
    logic                frame_error;
    err_code_t           err_code;
    logic                timeout_hit_c;

    // A byte on the expiry cycle takes priority over the timeout.
    assign timeout_hit_c = (state != s_IDLE) && !bus.i_RX_DATA_VALID &&
                           (gap_cnt == TIMEOUT_LAST);

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state       <= s_IDLE;
            gap_cnt     <= '0;
            run_xor     <= '0;
            cmd_q       <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;

            if (timeout_hit_c) begin
                state       <= s_IDLE;
                gap_cnt     <= '0;
                err_code    <= ERR_TIMEOUT;
                frame_error <= 1'b1;
            end else begin
                if ((state == s_IDLE) || bus.i_RX_DATA_VALID) begin
                    gap_cnt <= '0;
                end else begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end

                unique case (state)
                    s_IDLE: begin
                        if (bus.i_RX_DATA_VALID && (bus.i_DATA_RX == c_HEADER)) begin
                            state   <= s_CMD;
                            run_xor <= '0;
                        end
                    end
                    s_CMD: begin
                        if (bus.i_RX_DATA_VALID) begin
                            cmd_q   <= bus.i_DATA_RX;
                            run_xor <= run_xor ^ bus.i_DATA_RX;
                            state   <= s_DATA0;
                        end
                    end
                    s_DATA0: begin
                        if (bus.i_RX_DATA_VALID) begin
                            data0_q <= bus.i_DATA_RX;
                            run_xor <= run_xor ^ bus.i_DATA_RX;
                            state   <= s_DATA1;
                        end
                    end
                    s_DATA1: begin
                        if (bus.i_RX_DATA_VALID) begin
                            data1_q <= bus.i_DATA_RX;
                            run_xor <= run_xor ^ bus.i_DATA_RX;
                            state   <= s_CHECK;
                        end
                    end
                    s_CHECK: begin
                        if (bus.i_RX_DATA_VALID) begin
                            state <= s_IDLE;
                            if (bus.i_DATA_RX == run_xor) begin
                                frame.cmd   <= cmd_q;
                                frame.data  <= {data1_q, data0_q};
                                err_code    <= ERR_NONE;
                                frame_valid <= 1'b1;
                            end else begin
                                err_code    <= ERR_CHECKSUM;
                                frame_error <= 1'b1;
                            end
                        end
                    end
                    default: state <= s_IDLE;
                endcase
            end
        end
    end

    assign bus.o_FRAME_VALID = frame_valid;
    assign bus.o_FRAME_ERROR = frame_error;
    assign bus.o_CMD         = frame.cmd;
    assign bus.o_DATA        = frame.data;
    assign bus.o_ERR_CODE    = err_code;

endmodule
